// File: rtl/fib_iter_resp_pkg.sv
// Shared definitions for the Fibonacci responder: FSM state encoding and default widths.
package fib_iter_resp_pkg;

  localparam int FIB_N_IN  = 10;
  localparam int FIB_N_OUT = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fib_iter_resp_if.sv
// 4-phase req/ack handshake between the board-level initiator and the Fibonacci responder.
interface fib_iter_resp_if #(
  parameter int N_IN  = fib_iter_resp_pkg::FIB_N_IN,
  parameter int N_OUT = fib_iter_resp_pkg::FIB_N_OUT
);
  logic             req;
  logic [N_IN-1:0]  n;
  logic             ack;
  logic             busy;
  logic [N_OUT-1:0] result;
  logic             ovf;

  modport master (output req, n, input  ack, busy, result, ovf);
  modport slave  (input  req, n, output ack, busy, result, ovf);
endinterface

// File: rtl/fib_iter_resp_step.sv
// Fibonacci datapath: a=F(k), b=F(k+1) with sticky overflow flags, one addition per step.
module fib_iter_resp_step #(
  parameter int N_OUT = fib_iter_resp_pkg::FIB_N_OUT
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             load_i,
  input  logic             step_i,
  output logic [N_OUT-1:0] a_o,
  output logic             oa_o
);

  localparam logic [N_OUT-1:0] ONE = N_OUT'(1);

  logic [N_OUT-1:0] a_q, a_d, b_q, b_d;
  logic             oa_q, oa_d, ob_q, ob_d;
  logic [N_OUT:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    oa_d = oa_q;
    ob_d = ob_q;
    if (load_i) begin
      a_d  = '0;
      b_d  = ONE;
      oa_d = 1'b0;
      ob_d = 1'b0;
    end else if (step_i) begin
      a_d  = b_q;
      b_d  = sum[N_OUT-1:0];
      oa_d = ob_q;
      // Overflow is sticky: once either operand wrapped, every later term has too.
      ob_d = oa_q | ob_q | sum[N_OUT];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      a_q  <= '0;
      b_q  <= '0;
      oa_q <= 1'b0;
      ob_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      oa_q <= oa_d;
      ob_q <= ob_d;
    end
  end

  assign a_o  = a_q;
  assign oa_o = oa_q;

endmodule

// File: rtl/fib_iter_resp.sv
// Responder for the req/ack Fibonacci handshake: captures n, iterates F(n), holds result for display.
module fib_iter_resp
  import fib_iter_resp_pkg::*;
#(
  parameter int N_IN  = FIB_N_IN,
  parameter int N_OUT = FIB_N_OUT
) (
  input logic             clk,
  input logic             RSTN,
  fib_iter_resp_if.slave  bus
);

  localparam logic [N_IN-1:0] CNT_ONE = N_IN'(1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  cnt_q, cnt_d;
  logic [N_OUT-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             load, step;
  logic [N_OUT-1:0] a;
  logic             oa;

  fib_iter_resp_step #(.N_OUT(N_OUT)) u_step (
    .clk    (clk),
    .RSTN   (RSTN),
    .load_i (load),
    .step_i (step),
    .a_o    (a),
    .oa_o   (oa)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          load    = 1'b1;
          cnt_d   = bus.n;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // A dropped request aborts without touching the displayed result.
        if (!bus.req) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          result_d = a;
          ovf_d    = oa;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Decoding straight from the state register keeps busy and ack mutually exclusive.
  assign bus.busy   = (state_q == ST_CALC);
  assign bus.ack    = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_fib_iter_resp.sv
// Directed bench for fib_iter_resp: latency, boundary values, abort, hold and back-to-back requests.
module tb_fib_iter_resp;

  localparam int N_IN  = 10;
  localparam int N_OUT = 24;
  localparam int MAX_EDGES = 1100;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  fib_iter_resp_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  fib_iter_resp #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // busy and ack must never be high together on any cycle
  always @(negedge clk) begin
    if (rstn) begin
      n_cmp++;
      if (bus.busy && bus.ack) begin
        n_fail++;
        $display("FAIL busy_ack_excl t=%0t: busy=%b ack=%b, required not both 1", $time, bus.busy, bus.ack);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Raise req with index idx and wait for ack; checks latency, busy, result and ovf.
  task automatic run_req(input logic [N_IN-1:0] idx, input logic [N_OUT-1:0] exp_res,
                         input logic exp_ovf, input string name);
    int edges;
    bit got_ack;
    edges   = 0;
    got_ack = 0;
    @(negedge clk);
    bus.n   = idx;
    bus.req = 1'b1;
    while (!got_ack && edges < MAX_EDGES) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) chk({name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
      got_ack = bus.ack;
    end
    if (!got_ack) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no ack after %0d edges, required %0d", name, edges, int'(idx) + 2);
    end else begin
      chk({name, "_latency"}, 32'(edges), 32'(int'(idx) + 2));
      chk({name, "_result"}, 32'(bus.result), 32'(exp_res));
      chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
      chk({name, "_busy_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  // Drop req; ack must fall after exactly one edge with result retained.
  task automatic drop_req(input logic [N_OUT-1:0] exp_res, input string name);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_ack_fall"}, 32'(bus.ack), 32'd0);
    chk({name, "_result_kept"}, 32'(bus.result), 32'(exp_res));
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req = 1'b0;
    bus.n   = '0;
    rstn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_small();
    run_req(10'd0, 24'h000000, 1'b0, "n0");
    drop_req(24'h000000, "n0");
    run_req(10'd1, 24'h000001, 1'b0, "n1");
    drop_req(24'h000001, "n1");
    run_req(10'd10, 24'h000037, 1'b0, "n10");
    drop_req(24'h000037, "n10");
  endtask

  task automatic test_boundary();
    run_req(10'd36, 24'hE3D1B0, 1'b0, "n36");
    drop_req(24'hE3D1B0, "n36");
    run_req(10'd37, 24'h709E79, 1'b1, "n37");
    drop_req(24'h709E79, "n37");
    run_req(10'd20, 24'h001A6D, 1'b0, "n20");
    drop_req(24'h001A6D, "n20");
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    bus.n   = 10'd500;
    bus.req = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_busy_idle", 32'(bus.busy), 32'd0);
    chk("postrst_ack_idle", 32'(bus.ack), 32'd0);
    run_req(10'd1, 24'h000001, 1'b0, "postrst_n1");
    drop_req(24'h000001, "postrst_n1");
  endtask

  task automatic test_abort();
    run_req(10'd10, 24'h000037, 1'b0, "abort_pre");
    drop_req(24'h000037, "abort_pre");
    @(negedge clk);
    bus.n   = 10'd20;
    bus.req = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("abort_no_ack_calc", 32'(bus.ack), 32'd0);
    end
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_fall", 32'(bus.busy), 32'd0);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_result", 32'(bus.result), 32'h37);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_ack_later", 32'(bus.ack), 32'd0);
    chk("abort_result_later", 32'(bus.result), 32'h37);
    @(negedge clk);
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    run_req(10'd10, 24'h000037, 1'b0, "hold");
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.ack !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 24'h37) bad++;
    end
    chk("hold_50_cycles_bad", 32'(bad), 32'd0);
    drop_req(24'h000037, "hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_idle_result", 32'(bus.result), 32'h37);
  endtask

  task automatic test_back_to_back();
    run_req(10'd5, 24'h000005, 1'b0, "b2b_n5");
    drop_req(24'h000005, "b2b_n5");
    run_req(10'd6, 24'h000008, 1'b0, "b2b_n6");
    drop_req(24'h000008, "b2b_n6");
  endtask

  initial begin
    test_reset();
    test_small();
    test_boundary();
    test_reset_mid_calc();
    test_abort();
    test_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
